// File: rtl/encrypt_iter.sv
// Iterative DES encryptor with an enable/done/ack handshake; ROUNDS_PER_CYCLE Feistel rounds per clock.
// Define ENCRYPT_CBC_EN to add CBC chaining (iv, iv_load ports and a chain register).
module encrypt_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ack,
    input  logic [63:0] message,
    input  logic [63:0] DESkey,
`ifdef ENCRYPT_CBC_EN
    input  logic [63:0] iv,
    input  logic        iv_load,
`endif
    output logic [63:0] encrypted,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] LAST = 4'(16 / ROUNDS_PER_CYCLE - 1);

    // Permutation tables use DES numbering: entry i names the 1-based source bit, bit 1 = MSB.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // S1..S8, each 4 rows x 16 columns of nibbles, first entry in the most significant nibble.
    localparam logic [2047:0] SB = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_perm(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    // Row is the outer bit pair of each 6-bit group, column the inner four.
    function automatic logic [31:0] feistel(input logic [31:0] rr, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  b;
        int          idx;
        x = e_perm(rr) ^ k;
        s = '0;
        for (int n = 0; n < 8; n++) begin
            b   = x[47-6*n -: 6];
            idx = int'({b[5], b[0], b[4:1]});
            s[31-4*n -: 4] = SB[(7-n)*256 + (63-idx)*4 +: 4];
        end
        return p_perm(s);
    endfunction

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] lh, rh;
    logic [27:0] ch, dh;
    logic [31:0] lv, rv, tmp;
    logic [27:0] cv, dv;
    logic [47:0] subkey;
    logic [63:0] ip_in;
    logic [55:0] key56;
    logic [63:0] cipher;
    int          rnd;

`ifdef ENCRYPT_CBC_EN
    logic [63:0] chain;
    assign ip_in = message ^ chain;
`else
    assign ip_in = message;
`endif

    assign key56  = pc1_perm(DESkey);
    assign cipher = fp_perm({rv, lv});

    always_comb begin
        lv     = lh;
        rv     = rh;
        cv     = ch;
        dv     = dh;
        subkey = '0;
        tmp    = '0;
        rnd    = 0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            rnd = int'(cnt) * ROUNDS_PER_CYCLE + j + 1;
            if (rnd == 1 || rnd == 2 || rnd == 9 || rnd == 16) begin
                cv = {cv[26:0], cv[27]};
                dv = {dv[26:0], dv[27]};
            end else begin
                cv = {cv[25:0], cv[27:26]};
                dv = {dv[25:0], dv[27:26]};
            end
            subkey = pc2_perm({cv, dv});
            tmp    = lv ^ feistel(rv, subkey);
            lv     = rv;
            rv     = tmp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lh        <= '0;
            rh        <= '0;
            ch        <= '0;
            dh        <= '0;
            encrypted <= '0;
            done      <= 1'b0;
`ifdef ENCRYPT_CBC_EN
            chain     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef ENCRYPT_CBC_EN
                    if (iv_load) begin
                        chain <= iv;
                    end else if (enable) begin
`else
                    if (enable) begin
`endif
                        {lh, rh} <= ip_perm(ip_in);
                        {ch, dh} <= key56;
                        cnt      <= '0;
                        state    <= ROUND;
                    end
                end
                ROUND: begin
                    lh <= lv;
                    rh <= rv;
                    ch <= cv;
                    dh <= dv;
                    if (cnt == LAST) begin
                        encrypted <= cipher;
                        done      <= 1'b1;
                        state     <= DONE;
`ifdef ENCRYPT_CBC_EN
                        chain     <= cipher;
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
